// File: rtl/core_flush_seq.sv
// Pipeline flush/redirect sequencer: stalls fetch, flushes stages until drained
// (or the watchdog fires), then hands the new PC to the PC-select stage.
module core_flush_seq #(
  parameter int XLEN = 32,
  parameter int NSTG = 8,
  parameter int TMO  = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_req,
  input  logic [XLEN-1:0] flush_pc,
  input  logic [NSTG-1:0] stg_idle,
  input  logic            redirect_ready,
  output logic            fetch_stall,
  output logic [NSTG-1:0] stg_flush,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            busy,
  output logic            drain_err,
  output logic [15:0]     flush_cnt,
  output logic [1:0]      dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_HALT  = 2'd1,
    S_FLUSH = 2'd2,
    S_REDIR = 2'd3
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(TMO - 1);

  state_t          state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pend_pc;
  logic            pend_q;
  logic [7:0]      drain_q;
  logic            err_q;
  logic [15:0]     cnt_q;

  // Handshake (redirect_ready while in REDIR): redirect_valid is 1 exactly in
  // REDIR, and redirect_pc only changes after the cycle both are high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      pend_pc <= '0;
      pend_q  <= 1'b0;
      drain_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (flush_req) begin
            pc_q    <= flush_pc;
            state_q <= S_HALT;
          end
        end
        S_HALT: begin
          if (flush_req) pc_q <= flush_pc;
          drain_q <= '0;
          state_q <= S_FLUSH;
        end
        S_FLUSH: begin
          // A late request retargets and restarts the drain window.
          if (flush_req) begin
            pc_q    <= flush_pc;
            drain_q <= '0;
          end else if (drain_q != 8'd0 && (&stg_idle)) begin
            state_q <= S_REDIR;
          end else if (drain_q == TMO_LAST) begin
            err_q   <= 1'b1;
            state_q <= S_REDIR;
          end else begin
            drain_q <= drain_q + 8'd1;
          end
        end
        S_REDIR: begin
          if (redirect_ready) begin
            cnt_q  <= cnt_q + 16'd1;
            pend_q <= 1'b0;
            if (flush_req) begin
              pc_q    <= flush_pc;
              state_q <= S_HALT;
            end else if (pend_q) begin
              pc_q    <= pend_pc;
              state_q <= S_HALT;
            end else begin
              state_q <= S_IDLE;
            end
          end else if (flush_req) begin
            pend_q  <= 1'b1;
            pend_pc <= flush_pc;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign fetch_stall    = (state_q != S_IDLE);
  assign busy           = (state_q != S_IDLE);
  assign stg_flush      = {NSTG{state_q == S_FLUSH}};
  assign redirect_valid = (state_q == S_REDIR);
  assign redirect_pc    = (state_q == S_REDIR) ? pc_q : '0;
  assign drain_err      = err_q;
  assign flush_cnt      = cnt_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_core_flush_seq.sv
// Directed bench for core_flush_seq: one task per scenario, inline checks.
module tb_core_flush_seq;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_HALT  = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_REDIR = 2'd3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush_req = 1'b0;
  logic [31:0] flush_pc = '0;
  logic [7:0]  stg_idle = 8'hFF;
  logic        redirect_ready = 1'b1;
  logic        fetch_stall;
  logic [7:0]  stg_flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        busy;
  logic        drain_err;
  logic [15:0] flush_cnt;
  logic [1:0]  dbg_state;

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_cnt = '0;

  core_flush_seq #(.XLEN(32), .NSTG(8), .TMO(64)) dut (
    .clk(clk), .rst(rst), .flush_req(flush_req), .flush_pc(flush_pc),
    .stg_idle(stg_idle), .redirect_ready(redirect_ready),
    .fetch_stall(fetch_stall), .stg_flush(stg_flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .busy(busy), .drain_err(drain_err), .flush_cnt(flush_cnt),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    flush_req = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_cnt = '0;
  endtask

  // Issue a one-cycle flush_req; returns one tick later (sequencer in HALT).
  task automatic pulse_flush(input logic [31:0] pc);
    flush_req = 1'b1;
    flush_pc  = pc;
    tick();
    flush_req = 1'b0;
  endtask

  // Number of cycles spent in FLUSH from now on, bounded.
  task automatic count_flush(output int n);
    n = 0;
    while (dbg_state == S_FLUSH && n < 300) begin
      n++;
      tick();
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (dbg_state !== S_IDLE) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, S_IDLE); end
    checks++; if ({fetch_stall, busy, redirect_valid, drain_err} !== 4'b0) begin errors++; $display("FAIL reset_flags got=%b exp=0000", {fetch_stall, busy, redirect_valid, drain_err}); end
    checks++; if (stg_flush !== 8'h00) begin errors++; $display("FAIL reset_stg_flush got=%h exp=00", stg_flush); end
    checks++; if (redirect_pc !== 32'h0) begin errors++; $display("FAIL reset_redirect_pc got=%h exp=0", redirect_pc); end
    checks++; if (flush_cnt !== 16'h0) begin errors++; $display("FAIL reset_flush_cnt got=%h exp=0", flush_cnt); end
  endtask

  task automatic test_reset_mid_flush();
    stg_idle = 8'h00;
    redirect_ready = 1'b1;
    pulse_flush(32'h0000_1000);
    tick();
    tick();
    checks++; if (dbg_state !== S_FLUSH) begin errors++; $display("FAIL rmf_in_flush got=%0d exp=%0d", dbg_state, S_FLUSH); end
    rst = 1'b1;
    #1;
    checks++; if ({fetch_stall, busy, redirect_valid, drain_err, stg_flush} !== 12'h0) begin errors++; $display("FAIL rmf_async_clear got=%h exp=000", {fetch_stall, busy, redirect_valid, drain_err, stg_flush}); end
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
    checks++; if (dbg_state !== S_IDLE || redirect_valid !== 1'b0) begin errors++; $display("FAIL rmf_after_state got=%0d/%b exp=0/0", dbg_state, redirect_valid); end
    checks++; if (flush_cnt !== 16'h0) begin errors++; $display("FAIL rmf_flush_cnt got=%h exp=0", flush_cnt); end
    stg_idle = 8'hFF;
  endtask

  task automatic test_basic();
    int n;
    stg_idle = 8'hFF;
    redirect_ready = 1'b1;
    pulse_flush(32'h0000_1000);
    checks++; if (dbg_state !== S_HALT || fetch_stall !== 1'b1 || stg_flush !== 8'h00) begin errors++; $display("FAIL basic_halt got=%0d/%b/%h exp=1/1/00", dbg_state, fetch_stall, stg_flush); end
    tick();
    checks++; if (dbg_state !== S_FLUSH || stg_flush !== 8'hFF || fetch_stall !== 1'b1) begin errors++; $display("FAIL basic_flush got=%0d/%h/%b exp=2/ff/1", dbg_state, stg_flush, fetch_stall); end
    count_flush(n);
    checks++; if (n !== 2) begin errors++; $display("FAIL basic_flush_len got=%0d exp=2", n); end
    checks++; if (dbg_state !== S_REDIR || redirect_valid !== 1'b1 || redirect_pc !== 32'h1000 || stg_flush !== 8'h00) begin errors++; $display("FAIL basic_redir got=%0d/%b/%h/%h exp=3/1/1000/00", dbg_state, redirect_valid, redirect_pc, stg_flush); end
    tick();
    exp_cnt++;
    checks++; if (dbg_state !== S_IDLE || fetch_stall !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL basic_idle got=%0d/%b/%b exp=0/0/0", dbg_state, fetch_stall, busy); end
    checks++; if (flush_cnt !== exp_cnt) begin errors++; $display("FAIL basic_cnt got=%h exp=%h", flush_cnt, exp_cnt); end
  endtask

  task automatic test_slow_drain();
    int n;
    stg_idle = 8'h7F;
    redirect_ready = 1'b1;
    pulse_flush(32'h0000_1800);
    tick();
    n = 0;
    while (dbg_state == S_FLUSH && n < 300) begin
      n++;
      if (n == 11) stg_idle = 8'hFF;
      tick();
    end
    checks++; if (n !== 11) begin errors++; $display("FAIL slow_flush_len got=%0d exp=11", n); end
    checks++; if (dbg_state !== S_REDIR || drain_err !== 1'b0 || redirect_pc !== 32'h1800) begin errors++; $display("FAIL slow_redir got=%0d/%b/%h exp=3/0/1800", dbg_state, drain_err, redirect_pc); end
    tick();
    exp_cnt++;
    checks++; if (flush_cnt !== exp_cnt) begin errors++; $display("FAIL slow_cnt got=%h exp=%h", flush_cnt, exp_cnt); end
  endtask

  task automatic test_back_to_back();
    int n;
    stg_idle = 8'hFF;
    redirect_ready = 1'b1;
    pulse_flush(32'h0000_4000);
    tick();
    count_flush(n);
    flush_req = 1'b1;
    flush_pc  = 32'h0000_5000;
    checks++; if (redirect_pc !== 32'h4000) begin errors++; $display("FAIL b2b_first_pc got=%h exp=4000", redirect_pc); end
    tick();
    flush_req = 1'b0;
    exp_cnt++;
    checks++; if (dbg_state !== S_HALT || redirect_valid !== 1'b0 || flush_cnt !== exp_cnt) begin errors++; $display("FAIL b2b_halt got=%0d/%b/%h exp=1/0/%h", dbg_state, redirect_valid, flush_cnt, exp_cnt); end
    tick();
    count_flush(n);
    checks++; if (dbg_state !== S_REDIR || redirect_pc !== 32'h5000) begin errors++; $display("FAIL b2b_second_pc got=%0d/%h exp=3/5000", dbg_state, redirect_pc); end
    tick();
    exp_cnt++;
    checks++; if (dbg_state !== S_IDLE || flush_cnt !== exp_cnt) begin errors++; $display("FAIL b2b_end got=%0d/%h exp=0/%h", dbg_state, flush_cnt, exp_cnt); end
  endtask

  task automatic test_watchdog();
    int n;
    stg_idle = 8'h00;
    redirect_ready = 1'b1;
    pulse_flush(32'h0000_6000);
    tick();
    count_flush(n);
    checks++; if (n !== 64) begin errors++; $display("FAIL wd_flush_len got=%0d exp=64", n); end
    checks++; if (dbg_state !== S_REDIR || drain_err !== 1'b1 || redirect_pc !== 32'h6000) begin errors++; $display("FAIL wd_redir got=%0d/%b/%h exp=3/1/6000", dbg_state, drain_err, redirect_pc); end
    tick();
    exp_cnt++;
    stg_idle = 8'hFF;
    pulse_flush(32'h0000_7000);
    tick();
    count_flush(n);
    tick();
    exp_cnt++;
    checks++; if (drain_err !== 1'b1 || flush_cnt !== exp_cnt) begin errors++; $display("FAIL wd_sticky got=%b/%h exp=1/%h", drain_err, flush_cnt, exp_cnt); end
    do_reset();
    checks++; if (drain_err !== 1'b0) begin errors++; $display("FAIL wd_cleared got=%b exp=0", drain_err); end
  endtask

  task automatic test_overlap_flush();
    int n;
    do_reset();
    stg_idle = 8'hFF;
    redirect_ready = 1'b1;
    pulse_flush(32'h0000_1000);
    tick();
    flush_req = 1'b1;
    flush_pc  = 32'h0000_2000;
    tick();
    flush_req = 1'b0;
    count_flush(n);
    checks++; if (n !== 2) begin errors++; $display("FAIL ovf_restart_len got=%0d exp=2", n); end
    checks++; if (dbg_state !== S_REDIR || redirect_pc !== 32'h2000) begin errors++; $display("FAIL ovf_pc got=%0d/%h exp=3/2000", dbg_state, redirect_pc); end
    repeat (4) tick();
    checks++; if (dbg_state !== S_IDLE || flush_cnt !== 16'd1) begin errors++; $display("FAIL ovf_single got=%0d/%h exp=0/1", dbg_state, flush_cnt); end
  endtask

  task automatic test_overlap_redir();
    int n;
    do_reset();
    stg_idle = 8'hFF;
    redirect_ready = 1'b0;
    pulse_flush(32'h0000_1000);
    tick();
    count_flush(n);
    flush_req = 1'b1;
    flush_pc  = 32'h0000_3000;
    for (int i = 0; i < 3; i++) begin
      checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h1000) begin errors++; $display("FAIL ovr_stable_%0d got=%b/%h exp=1/1000", i, redirect_valid, redirect_pc); end
      tick();
      flush_req = 1'b0;
    end
    redirect_ready = 1'b1;
    tick();
    checks++; if (dbg_state !== S_HALT || flush_cnt !== 16'd1) begin errors++; $display("FAIL ovr_pending got=%0d/%h exp=1/1", dbg_state, flush_cnt); end
    tick();
    count_flush(n);
    checks++; if (n !== 2 || redirect_pc !== 32'h3000) begin errors++; $display("FAIL ovr_second got=%0d/%h exp=2/3000", n, redirect_pc); end
    tick();
    checks++; if (dbg_state !== S_IDLE || flush_cnt !== 16'd2) begin errors++; $display("FAIL ovr_cnt got=%0d/%h exp=0/2", dbg_state, flush_cnt); end
  endtask

  task automatic test_wrap();
    int n;
    stg_idle = 8'hFF;
    redirect_ready = 1'b1;
    force dut.cnt_q = 16'hFFFF;
    tick();
    release dut.cnt_q;
    tick();
    checks++; if (flush_cnt !== 16'hFFFF) begin errors++; $display("FAIL wrap_preload got=%h exp=ffff", flush_cnt); end
    pulse_flush(32'h0000_8000);
    tick();
    count_flush(n);
    tick();
    checks++; if (flush_cnt !== 16'h0000 || dbg_state !== S_IDLE) begin errors++; $display("FAIL wrap_cnt got=%h/%0d exp=0000/0", flush_cnt, dbg_state); end
  endtask

  initial begin
    test_reset();
    test_reset_mid_flush();
    test_basic();
    test_slow_drain();
    test_back_to_back();
    test_watchdog();
    test_overlap_flush();
    test_overlap_redir();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/core_flush_seq.md
CORE_FLUSH_SEQ -- requirements
Module: core_flush_seq

Interface
REQ-001 SHALL have parameter XLEN, default 32, width of PC values.
REQ-002 SHALL have parameter NSTG, default 8, number of flushable pipeline stages (page walker, loader, decoder, RSV1-4, reg mng).
REQ-003 SHALL have parameter TMO, default 64, drain watchdog limit in cycles (range 2..255).
REQ-004 SHALL have one clock; reset is asynchronous and active-high: ports clk (in, 1, rising-edge clock) and rst (in, 1, async active-high reset).
REQ-005 flush_req  in  1  single-cycle pulse: redirect required (mispredict/exception from ROB commit).
REQ-006 flush_pc  in  XLEN  target PC, sampled with flush_req.
REQ-007 stg_idle  in  NSTG  per-stage "empty, no in-flight op" status.
REQ-008 redirect_ready  in  1  PC-select stage accepts redirect.
REQ-009 fetch_stall  out  1  hold instruction fetch.
REQ-010 stg_flush  out  NSTG  per-stage flush command.
REQ-011 redirect_valid  out  1  redirect_pc is valid.
REQ-012 redirect_pc  out  XLEN  new fetch PC.
REQ-013 busy  out  1  sequencer not in IDLE.
REQ-014 drain_err  out  1  sticky watchdog error.
REQ-015 flush_cnt  out  16  completed-redirect counter.

Function
REQ-016 SHALL implement FSM states IDLE, HALT, FLUSH, REDIR.
REQ-017 IDLE: on flush_req, SHALL latch flush_pc into pc_q and enter HALT next cycle.
REQ-018 HALT: SHALL last exactly one cycle with fetch_stall=1, stg_flush=0, then enter FLUSH.
REQ-019 FLUSH: SHALL drive fetch_stall=1 and stg_flush all-ones; an 8-bit drain counter SHALL reset to 0 on entry and increment each FLUSH cycle.
REQ-020 FLUSH SHALL exit to REDIR in the first cycle in which stg_idle is all-ones, evaluated no earlier than the second FLUSH cycle (minimum FLUSH length 2 cycles).
REQ-021 If the drain counter reaches TMO-1 without all-idle, SHALL set drain_err=1 (sticky until reset) and enter REDIR anyway.
REQ-022 REDIR: SHALL drive redirect_valid=1, redirect_pc=pc_q, fetch_stall=1, stg_flush=0; redirect_pc SHALL stay stable while redirect_valid=1 and redirect_ready=0.
REQ-023 REDIR handshake completes when redirect_valid and redirect_ready are both 1; flush_cnt SHALL then increment by 1, wrapping 0xFFFF->0x0000.
REQ-024 On handshake with no pending request, SHALL return to IDLE; fetch_stall SHALL deassert in the IDLE cycle.
REQ-025 flush_req in HALT or FLUSH SHALL overwrite pc_q (last request wins) and restart the drain counter at 0 without leaving FLUSH.
REQ-026 flush_req in REDIR SHALL be held in pend_q/pend_pc without changing redirect_pc; after handshake, SHALL go to HALT with pc_q=pend_pc and clear pend_q.
REQ-027 flush_req coincident with handshake cycle SHALL behave as REQ-026.
REQ-028 busy SHALL equal (state != IDLE).
REQ-029 All outputs SHALL be registered or decoded from state only, never combinationally from inputs.

Reset
REQ-030 On rst=1, SHALL asynchronously enter IDLE; fetch_stall=0, stg_flush=0, redirect_valid=0, redirect_pc=0, busy=0, drain_err=0, flush_cnt=0, pend_q=0, pc_q=0.
REQ-031 Reset asserted mid-sequence SHALL abort the sequence with no redirect and no count increment; the first cycle after deassertion SHALL be IDLE.

Verification
REQ-032 Basic: flush_req, flush_pc=0x1000, stg_idle all-ones, redirect_ready=1 -> HALT 1 cycle, FLUSH 2 cycles, REDIR 1 cycle with redirect_pc=0x1000, flush_cnt=1, IDLE.
REQ-033 Slow drain: stg_idle=0x7F for 10 cycles then 0xFF -> FLUSH lasts 11 cycles, drain_err=0.
REQ-034 Watchdog: stg_idle stuck 0x00, TMO=64 -> REDIR after 64 FLUSH cycles, drain_err=1, held through later flushes until rst.
REQ-035 Overlap: second flush_req (pc 0x2000) in FLUSH -> single redirect to 0x2000, flush_cnt=1; flush_req (0x3000) during REDIR with redirect_ready=0 for 3 cycles -> redirect 0x1000 stable, then full second sequence to 0x3000, flush_cnt=2.
REQ-036 Reset mid-FLUSH -> all outputs zero immediately, no redirect_valid, flush_cnt unchanged at 0.
REQ-037 Wrap: preload flush_cnt to 0xFFFF via 65535 flushes (or forced) -> next redirect gives 0x0000.
